// File: rtl/sprite_overlay_ctrl.sv
// Game-over sprite sequencer: IDLE/PLAY/SLIDE/HOLD phases with frame-aligned placement updates.
// Optional HOLD-phase blink is built only when SPRITE_BLINK_EN is defined.
module sprite_overlay_ctrl #(
   parameter int IMG_W        = 344,
   parameter int IMG_H        = 80,
   parameter int X_POS        = 148,
   parameter int TARGET_Y     = 200,
   parameter int SLIDE_STEP   = 8,
   parameter int HOLD_FRAMES  = 300,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        start_btn,
   input  logic        game_over,
   output logic        switch,
   output logic [10:0] x0,
   output logic [10:0] x1,
   output logic [10:0] y0,
   output logic [10:0] y1,
   output logic        game_run,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      SLIDE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int HCW = $clog2(HOLD_FRAMES + 1);

   if (TARGET_Y + IMG_H > 2047 || SLIDE_STEP < 1 || HOLD_FRAMES < 1 ||
       BLINK_FRAMES < 1 || TARGET_Y < 1) begin : g_bad_params
      $error("sprite_overlay_ctrl: invalid parameter set");
   end

   state_t         st;
   logic           pending;
   logic [HCW-1:0] hold_cnt;
   logic           start_now;
   logic [11:0]    y_sum;
   logic [10:0]    y_slide;

`ifdef SPRITE_BLINK_EN
   localparam int BCW = $clog2(BLINK_FRAMES + 1);
   logic [BCW-1:0] blink_cnt;
`endif

   assign state     = st;
   // A start coincident with the tick is consumed by that same tick.
   assign start_now = pending | start_btn;
   assign y_sum     = 12'(y0) + 12'(SLIDE_STEP);
   assign y_slide   = (y_sum >= 12'(TARGET_Y)) ? 11'(TARGET_Y) : y_sum[10:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         switch    <= 1'b0;
         game_run  <= 1'b0;
         x0        <= 11'(X_POS);
         x1        <= 11'(X_POS + IMG_W);
         y0        <= 11'd0;
         y1        <= 11'(IMG_H);
         pending   <= 1'b0;
         hold_cnt  <= '0;
`ifdef SPRITE_BLINK_EN
         blink_cnt <= '0;
`endif
      end else begin
         x0 <= 11'(X_POS);
         x1 <= 11'(X_POS + IMG_W);
         if (frame_tick) begin
            pending <= 1'b0;
            case (st)
               IDLE: begin
                  if (start_now) begin
                     st       <= PLAY;
                     game_run <= 1'b1;
                     switch   <= 1'b0;
                  end
               end
               PLAY: begin
                  if (game_over) begin
                     st       <= SLIDE;
                     game_run <= 1'b0;
                     switch   <= 1'b1;
                     y0       <= 11'd0;
                     y1       <= 11'(IMG_H);
                  end
               end
               SLIDE: begin
                  // Pending starts are simply dropped here by the pending clear above.
                  y0 <= y_slide;
                  y1 <= y_slide + 11'(IMG_H);
                  if (y_slide == 11'(TARGET_Y)) begin
                     st        <= HOLD;
                     switch    <= 1'b1;
                     hold_cnt  <= '0;
`ifdef SPRITE_BLINK_EN
                     blink_cnt <= '0;
`endif
                  end
               end
               HOLD: begin
                  if (start_now) begin
                     st        <= PLAY;
                     game_run  <= 1'b1;
                     switch    <= 1'b0;
                     y0        <= 11'd0;
                     y1        <= 11'(IMG_H);
                     hold_cnt  <= '0;
`ifdef SPRITE_BLINK_EN
                     blink_cnt <= '0;
`endif
                  end else if (hold_cnt == HCW'(HOLD_FRAMES - 1)) begin
                     st       <= IDLE;
                     switch   <= 1'b0;
                     hold_cnt <= '0;
`ifdef SPRITE_BLINK_EN
                     blink_cnt <= '0;
`endif
                  end else begin
                     hold_cnt <= hold_cnt + HCW'(1);
`ifdef SPRITE_BLINK_EN
                     if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
                        blink_cnt <= '0;
                        switch    <= ~switch;
                     end else begin
                        blink_cnt <= blink_cnt + BCW'(1);
                     end
`endif
                  end
               end
               default: st <= IDLE;
            endcase
         end else if (start_btn) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sprite_overlay_ctrl.sv
// Bench for sprite_overlay_ctrl: directed phase walk plus random traffic against a frame-level model.
module tb_sprite_overlay_ctrl;

   localparam int IMG_W        = 344;
   localparam int IMG_H        = 80;
   localparam int X_POS        = 148;
   localparam int TARGET_Y     = 200;
   localparam int SLIDE_STEP   = 8;
   localparam int HOLD_FRAMES  = 300;
   localparam int BLINK_FRAMES = 30;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        start_btn = 1'b0;
   logic        game_over = 1'b0;
   logic        switch;
   logic [10:0] x0, x1, y0, y1;
   logic        game_run;
   logic [1:0]  state;

   sprite_overlay_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .X_POS(X_POS), .TARGET_Y(TARGET_Y),
      .SLIDE_STEP(SLIDE_STEP), .HOLD_FRAMES(HOLD_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
      .game_over(game_over), .switch(switch), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
      .game_run(game_run), .state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Frame-level model: phase, slide frames elapsed, hold frames elapsed.
   int  m_phase = 0;
   int  m_y = 0;
   int  m_slide = 0;
   int  m_hold = 0;
   bit  m_pend = 0;
   bit  go_lvl = 0;

   function automatic int exp_switch();
      if (m_phase == 2) return 1;
      if (m_phase == 3) begin
`ifdef SPRITE_BLINK_EN
         return ((m_hold / BLINK_FRAMES) % 2 == 0) ? 1 : 0;
`else
         return 1;
`endif
      end
      return 0;
   endfunction

   task automatic model(input bit t, input bit b, input bit g, input bit r);
      bit s;
      if (r) begin
         m_phase = 0; m_y = 0; m_slide = 0; m_hold = 0; m_pend = 0;
      end else if (t) begin
         s = m_pend | b;
         m_pend = 0;
         case (m_phase)
            0: if (s) m_phase = 1;
            1: if (g) begin m_phase = 2; m_y = 0; m_slide = 0; end
            2: begin
               m_slide++;
               m_y = (m_slide * SLIDE_STEP > TARGET_Y) ? TARGET_Y : m_slide * SLIDE_STEP;
               if (m_y == TARGET_Y) begin m_phase = 3; m_hold = 0; end
            end
            default: begin
               if (s) begin m_phase = 1; m_y = 0; m_hold = 0; end
               else begin
                  m_hold++;
                  if (m_hold == HOLD_FRAMES) begin m_phase = 0; m_hold = 0; end
               end
            end
         endcase
      end else if (b) begin
         m_pend = 1;
      end
   endtask

   task automatic check();
      checks++;
      assert (state === 2'(m_phase)) else begin
         errors++; $error("FAIL state got %0d exp %0d", state, m_phase); end
      checks++;
      assert (switch === 1'(exp_switch())) else begin
         errors++; $error("FAIL switch got %0b exp %0d (hold %0d)", switch, exp_switch(), m_hold); end
      checks++;
      assert (game_run === (m_phase == 1)) else begin
         errors++; $error("FAIL game_run got %0b exp %0b", game_run, m_phase == 1); end
      checks++;
      assert (y0 === 11'(m_y)) else begin
         errors++; $error("FAIL y0 got %0d exp %0d", y0, m_y); end
      checks++;
      assert (y1 === 11'(m_y + IMG_H)) else begin
         errors++; $error("FAIL y1 got %0d exp %0d", y1, m_y + IMG_H); end
      checks++;
      assert (x0 === 11'(X_POS)) else begin
         errors++; $error("FAIL x0 got %0d exp %0d", x0, X_POS); end
      checks++;
      assert (x1 === 11'(X_POS + IMG_W)) else begin
         errors++; $error("FAIL x1 got %0d exp %0d", x1, X_POS + IMG_W); end
   endtask

   // One clock: drive, advance model at the edge, check 1 time unit later.
   task automatic step(input bit t, input bit b, input bit r);
      frame_tick = t; start_btn = b; game_over = go_lvl; rst = r;
      @(posedge clk);
      model(t, b, go_lvl, r);
      #1;
      frame_tick = 1'b0; start_btn = 1'b0; rst = 1'b0;
      check();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0);
         repeat ($urandom_range(0, 2)) step(0, 0, 0);
      end
   endtask

   initial begin
      // reset
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 0);

      // mid-frame start waits for the tick
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);

      // game over -> slide; starts during slide are dropped
      go_lvl = 1;
      step(1, 0, 0);
      go_lvl = 0;
      ticks(5);
      step(0, 1, 0);
      ticks(5);
      step(1, 1, 0);
      ticks(14);
      // hold expires to idle
      ticks(HOLD_FRAMES);
      ticks(2);

      // again, with start on the expiry tick
      step(1, 1, 0);
      go_lvl = 1;
      step(1, 0, 0);
      go_lvl = 0;
      ticks(25);
      ticks(HOLD_FRAMES - 1);
      step(1, 1, 0);
      ticks(1);

      // hold expiry pre-empted by a mid-frame pending start
      go_lvl = 1;
      step(1, 0, 0);
      go_lvl = 0;
      ticks(25);
      ticks(HOLD_FRAMES - 1);
      step(0, 1, 0);
      step(1, 0, 0);

      // reset mid-slide at y0 = 96 drops a pending start
      go_lvl = 1;
      step(1, 0, 0);
      go_lvl = 0;
      for (int i = 0; i < 40 && m_y != 96; i++) step(1, 0, 0);
      step(0, 1, 0);
      step(0, 0, 1);
      step(1, 0, 0);
      step(1, 0, 0);

      // random traffic
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 99) < 3) go_lvl = ~go_lvl;
         step(($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 1999) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
